// File: rtl/qysys_test_mem_stream_writer.sv
// Stream-to-memory writer: buffers incoming stream words in a small FIFO and
// writes them to consecutive word addresses of an on-chip memory slave,
// starting at a job's base address and wrapping modulo 1024.
module qysys_test_mem_stream_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic [10:0] word_count,
  input  logic [31:0] snk_data,
  input  logic        snk_valid,
  output logic        snk_ready,
  input  logic        mem_grant,
  output logic [9:0]  mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  curAddr_q, curAddr_d;
  logic [10:0] acceptLeft_q, acceptLeft_d;
  logic [10:0] writeLeft_q, writeLeft_d;
  logic        zeroDone_q, zeroDone_d;

  logic [31:0] fifoMem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q, rdPtr_q;

  logic fifoEmpty;
  logic fifoFull;
  logic inRun;
  logic pushEn;
  logic popEn;

  // FIFO occupancy flags come from registered pointers only, so a pop in a
  // full cycle cannot re-open snk_ready until the following cycle.
  always_comb begin
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    inRun     = (state_q == RUN);
  end

  // Handshake and memory-port outputs; everything is held quiet while reset
  // is asserted so an aborted job cannot leak a write in the reset cycle.
  always_comb begin
    snk_ready      = inRun && !fifoFull && (acceptLeft_q != 11'd0) && !reset;
    pushEn         = snk_valid && snk_ready;
    popEn          = inRun && !fifoEmpty && mem_grant && !reset;
    mem_chipselect = popEn;
    mem_write      = popEn;
    mem_address    = curAddr_q;
    mem_writedata  = fifoMem_q[rdPtr_q[AW-1:0]];
    mem_byteenable = 4'hF;
    mem_clken      = 1'b1;
    busy           = ((state_q == RUN) || (state_q == DONE)) && !reset;
    done           = ((state_q == DONE) || zeroDone_q) && !reset;
  end

  // Next-state logic: job launch, per-word bookkeeping and completion.
  always_comb begin
    state_d      = state_q;
    curAddr_d    = curAddr_q;
    acceptLeft_d = acceptLeft_q;
    writeLeft_d  = writeLeft_q;
    zeroDone_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != 11'd0) begin
            state_d      = RUN;
            curAddr_d    = base_addr;
            acceptLeft_d = word_count;
            writeLeft_d  = word_count;
          end else begin
            zeroDone_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (pushEn) begin
          acceptLeft_d = acceptLeft_q - 11'd1;
        end
        if (popEn) begin
          curAddr_d   = curAddr_q + 10'd1;
          writeLeft_d = writeLeft_q - 11'd1;
          if (writeLeft_q == 11'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      curAddr_q    <= '0;
      acceptLeft_q <= '0;
      writeLeft_q  <= '0;
      zeroDone_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      curAddr_q    <= curAddr_d;
      acceptLeft_q <= acceptLeft_d;
      writeLeft_q  <= writeLeft_d;
      zeroDone_q   <= zeroDone_d;
    end
  end

  // FIFO pointers; reset empties the buffer and discards any held words.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= snk_data;
    end
  end

endmodule

// File: tb/tb_qysys_test_mem_stream_writer.sv
// Directed bench for the stream-to-memory writer: expected (address, data)
// pairs are queued when a job is launched and checked as writes appear.
module tb_qysys_test_mem_stream_writer;

  localparam int FIFO_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;
  logic        mem_grant;
  logic [9:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  logic [41:0] expQ[$];
  int cycle        = 0;
  int writesSeen   = 0;
  int doneSeen     = 0;
  int lastWriteCyc = 0;
  int doneCyc      = 0;
  int jobFirstW    = -1;

  qysys_test_mem_stream_writer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .mem_grant      (mem_grant),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: each observed write pops the next expected pair.
  always @(negedge clk) begin
    logic [41:0] e;
    cycle++;
    if (mem_write === 1'b1) begin
      writesSeen++;
      lastWriteCyc = cycle;
      if (jobFirstW < 0) jobFirstW = cycle;
      checkOutput("wrChipselect", 32'(mem_chipselect), 32'd1);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wrAddress", 32'(mem_address), 32'(e[41:32]));
        checkOutput("wrData", mem_writedata, e[31:0]);
      end
    end
    if (done === 1'b1) begin
      doneSeen++;
      doneCyc = cycle;
    end
  end

  // Launch a job, stream words from seed upward and check its completion.
  task automatic applyStimulus(input string name, input logic [9:0] base,
                               input int cnt, input int offered,
                               input logic [31:0] seed, input int grantDelay,
                               input int startPulseAt, input bit backToBack);
    int  idx;
    int  cyc;
    int  w0;
    int  d0;
    bit  acc;
    for (int i = 0; i < cnt; i++) begin
      expQ.push_back({10'(int'(base) + i), seed + 32'(i)});
    end
    w0 = writesSeen;
    d0 = doneSeen;
    jobFirstW = -1;
    start      = 1'b1;
    base_addr  = base;
    word_count = 11'(cnt);
    tick();
    start = 1'b0;
    checkOutput({name, ":busyAfterStart"}, 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    while (doneSeen == d0 && cyc < 300) begin
      snk_valid  = (idx < offered);
      snk_data   = seed + 32'(idx);
      mem_grant  = (cyc >= grantDelay);
      start      = (cyc == startPulseAt);
      base_addr  = 10'h155;
      word_count = 11'd2;
      if (grantDelay > 0 && cyc == grantDelay) begin
        checkOutput({name, ":stallAccepted"}, 32'(idx), 32'(FIFO_DEPTH));
        checkOutput({name, ":stallReady"}, 32'(snk_ready), 32'd0);
      end
      acc = snk_valid && snk_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    start     = 1'b0;
    snk_valid = 1'b0;
    checkOutput({name, ":donePulses"}, 32'(doneSeen - d0), 32'd1);
    checkOutput({name, ":writes"}, 32'(writesSeen - w0), 32'(cnt));
    checkOutput({name, ":accepted"}, 32'(idx), 32'(cnt));
    checkOutput({name, ":queueDrained"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, ":doneAfterLast"}, 32'(doneCyc), 32'(lastWriteCyc + 1));
    if (backToBack) begin
      checkOutput({name, ":writeSpan"}, 32'(lastWriteCyc - jobFirstW), 32'(cnt - 1));
    end
    checkOutput({name, ":idleBusy"}, 32'(busy), 32'd0);
    checkOutput({name, ":idleReady"}, 32'(snk_ready), 32'd0);
    tick();
    checkOutput({name, ":doneSingle"}, 32'(doneSeen - d0), 32'd1);
  endtask

  initial begin
    int w0;
    int d0;
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    snk_data   = '0;
    snk_valid  = 1'b0;
    mem_grant  = 1'b1;

    // Reset behaviour: outputs quiet during reset and the cycle after.
    tick();
    checkOutput("rstReady", 32'(snk_ready), 32'd0);
    checkOutput("rstWrite", 32'(mem_write), 32'd0);
    checkOutput("rstCs", 32'(mem_chipselect), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("postRstReady", 32'(snk_ready), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    checkOutput("byteEnable", 32'(mem_byteenable), 32'hF);
    checkOutput("clken", 32'(mem_clken), 32'd1);

    // Back-to-back job, then address wrap with an ignored start in RUN.
    applyStimulus("basic", 10'h010, 4, 4, 32'hA0, 0, -1, 1'b1);
    applyStimulus("wrap", 10'h3FE, 4, 4, 32'hB0, 0, 1, 1'b1);

    // Memory stalled for ten cycles: the FIFO fills and stops accepting.
    applyStimulus("stall", 10'h040, 8, 8, 32'h100, 10, -1, 1'b0);

    // Surplus stream words beyond the job length stay unaccepted.
    applyStimulus("surplus", 10'h060, 3, 5, 32'h200, 0, -1, 1'b1);

    // Zero-length job: done next cycle, nothing written, still idle.
    w0 = writesSeen;
    start      = 1'b1;
    word_count = 11'd0;
    base_addr  = 10'h070;
    tick();
    start = 1'b0;
    checkOutput("zeroDone", 32'(done), 32'd1);
    checkOutput("zeroBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("zeroDoneDrop", 32'(done), 32'd0);
    checkOutput("zeroNoWrite", 32'(writesSeen - w0), 32'd0);

    // Abort after two of six writes, then a fresh job from a new base.
    for (int i = 0; i < 6; i++) begin
      expQ.push_back({10'(10'h080 + i), 32'hC0 + 32'(i)});
    end
    w0 = writesSeen;
    d0 = doneSeen;
    start      = 1'b1;
    base_addr  = 10'h080;
    word_count = 11'd6;
    tick();
    start     = 1'b0;
    snk_valid = 1'b1;
    snk_data  = 32'hC0;
    mem_grant = 1'b1;
    cyc = 0;
    while (writesSeen - w0 < 2 && cyc < 50) begin
      if (snk_ready) begin
        tick();
        snk_data = snk_data + 32'd1;
      end else begin
        tick();
      end
      cyc++;
    end
    checkOutput("abortWritesBefore", 32'(writesSeen - w0), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("abortRstWrite", 32'(mem_write), 32'd0);
    checkOutput("abortRstReady", 32'(snk_ready), 32'd0);
    checkOutput("abortRstBusy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("abortIdleBusy", 32'(busy), 32'd0);
    checkOutput("abortIdleReady", 32'(snk_ready), 32'd0);
    checkOutput("abortIdleWrite", 32'(mem_write), 32'd0);
    repeat (5) tick();
    checkOutput("abortNoMoreWrites", 32'(writesSeen - w0), 32'd2);
    checkOutput("abortNoDone", 32'(doneSeen - d0), 32'd0);
    snk_valid = 1'b0;
    expQ.delete();
    applyStimulus("afterAbort", 10'h200, 3, 3, 32'hD0, 0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/qysys_test_mem_stream_writer.md
QYSYS_TEST_MEM_STREAM_WRITER -- requirements
Module: qysys_test_mem_stream_writer

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; every port listed is exactly as below.
REQ-002 FIFO_DEPTH, default 4, SHALL set the internal word-buffer depth (power of two, >= 2).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  single-cycle job request; sampled only in IDLE.
REQ-006 base_addr  in  10  first word address of the job, latched on an accepted start.
REQ-007 word_count  in  11  number of words to write, 0..1024, latched on an accepted start.
REQ-008 snk_data  in  32  stream word.
REQ-009 snk_valid  in  1  stream word is present.
REQ-010 snk_ready  out  1  the block accepts snk_data this cycle.
REQ-011 mem_grant  in  1  the memory port is available to this block this cycle.
REQ-012 mem_address  out  10  word address driven to the on-chip memory slave.
REQ-013 mem_writedata  out  32  write data to the memory.
REQ-014 mem_byteenable  out  4  byte enables, constant 4'hF.
REQ-015 mem_chipselect, mem_write  out  1 each  both asserted only on write cycles.
REQ-016 mem_clken  out  1  constant 1.
REQ-017 busy  out  1  high in RUN and DONE.
REQ-018 done  out  1  single-cycle job-complete pulse.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 IDLE -> RUN: start=1 and word_count!=0; base_addr and word_count are latched into cur_addr, accept_left and write_left.
REQ-021 start=1 with word_count=0 in IDLE SHALL produce done=1 on the next cycle, write nothing, and remain IDLE.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 snk_ready = (state==RUN) & fifo_not_full & (accept_left!=0); a word is accepted when snk_valid & snk_ready, which pushes it and decrements accept_left.
REQ-024 Write condition: state==RUN & fifo_not_empty & mem_grant; when it holds, mem_chipselect=mem_write=1, mem_address=cur_addr, mem_writedata=FIFO head, all combinational in that cycle.
REQ-025 Each write SHALL pop the FIFO, increment cur_addr modulo 1024 (1023 wraps to 0), and decrement write_left.
REQ-026 When no write occurs, mem_chipselect=mem_write=0 and mem_address/mem_writedata are don't-care.
REQ-027 Push and pop in the same cycle SHALL both occur; when full, the simultaneous pop does not re-enable snk_ready in that cycle.
REQ-028 An accepted word SHALL be written no earlier than the cycle after acceptance; with mem_grant held at 1 and snk_valid held at 1, sustained throughput is one word per cycle.
REQ-029 The write that takes write_left from 1 to 0 SHALL move RUN -> DONE; DONE asserts done=1 for exactly one cycle and then returns to IDLE.
REQ-030 The block SHALL never accept more than word_count words per job; surplus stream words stay unaccepted.

Reset
REQ-031 Reset SHALL force IDLE, empty the FIFO, and clear cur_addr, accept_left and write_left.
REQ-032 While reset is high and in the following cycle: snk_ready=0, mem_chipselect=0, mem_write=0, busy=0, done=0.
REQ-033 Reset asserted mid-job SHALL abort the job; no done pulse is issued and buffered words are discarded.

Verification
REQ-034 base=0x010, count=4, data 0xA0..0xA3 streamed back-to-back, grant=1 -> writes to 0x010..0x013 on consecutive cycles; done pulses once the cycle after the last write.
REQ-035 base=0x3FE, count=4, grant=1 -> write addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-036 count=8, grant=0 for 10 cycles then 1 -> exactly FIFO_DEPTH words accepted while grant=0 (snk_ready then 0), all 8 written in order, no loss or duplication.
REQ-037 count=3 with 5 valid words offered -> 3 accepted; snk_ready stays 0 afterwards; done=1.
REQ-038 start with count=0 -> done on the next cycle, no mem_write; start pulsed during RUN -> ignored.
REQ-039 reset after 2 of 6 writes -> IDLE the next cycle, no further writes, no done; a new job then runs correctly from its base_addr.
